// File: rtl/svi_rr_scheduler.sv
// -----------------------------------------------------------------------------
// svi_rr_scheduler
//
// Round-robin scheduler that hands one shared downstream resource to one of
// SIZE requester lanes at a time. The grant is registered and one-hot, and
// comes with an encoded owner index. The surrounding datapath uses the index
// to steer the owning lane onto the resource.
//
// Ownership ends when one of these happens:
//    - the owner pulses i_done,
//    - the owner drops its request,
//    - the hold timeout expires (only when built with the timeout feature).
// After every ownership there is exactly one bubble cycle (RELEASE) before
// the next arbitration.
//
// Build option:
//    SVI_RR_SCHED_TIMEOUT_EN
//       Defined   : a grant is revoked once it has been held for HOLD_MAX
//                   cycles. The revoked lane re-enters arbitration behind
//                   every other requester.
//       Undefined : grants last until i_done or a request drop. HOLD_MAX is
//                   ignored. o_hold_cnt still counts and saturates.
//
// Parameters:
//    SIZE       number of requester lanes (>= 2)
//    HOLD_MAX   longest grant in cycles when the timeout is built in (>= 1)
//
// Ports:
//    i_clk       in   1                     rising-edge clock
//    i_arst_n    in   1                     asynchronous active-low reset
//    i_req       in   SIZE                  request level, bit n = lane n
//    i_done      in   1                     owner finished (sampled in GRANT only)
//    o_gnt       out  SIZE                  one-hot grant, zero when no owner
//    o_gnt_idx   out  clog2(SIZE)           current owner, or last owner when idle
//    o_valid     out  1                     a grant is active (== |o_gnt)
//    o_hold_cnt  out  clog2(HOLD_MAX+1)     cycles in current grant, 1 on the first
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module svi_rr_scheduler #(
   parameter int SIZE     = 8,
   parameter int HOLD_MAX = 4
) (
   input  logic                          i_clk,
   input  logic                          i_arst_n,
   input  logic [SIZE-1:0]               i_req,
   input  logic                          i_done,
   output logic [SIZE-1:0]               o_gnt,
   output logic [$clog2(SIZE)-1:0]       o_gnt_idx,
   output logic                          o_valid,
   output logic [$clog2(HOLD_MAX+1)-1:0] o_hold_cnt
);

   localparam int IDX_W  = $clog2(SIZE);
   localparam int HOLD_W = $clog2(HOLD_MAX + 1);

   // The pointer resets to the top lane, so the first search starts at lane 0.
   localparam logic [IDX_W-1:0]  IDX_RESET = IDX_W'(SIZE - 1);
   localparam logic [HOLD_W-1:0] HOLD_LIM  = HOLD_W'(HOLD_MAX);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

`ifdef SVI_RR_SCHED_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  winner;
   logic [SIZE-1:0]   win_onehot;
   logic              timeout_hit;
   logic              release_cond;

   // --------------------------------------------------------------------------
   // Circular priority search.
   // Lanes are visited starting one past the pointer and wrapping from SIZE-1
   // to 0. The loop walks from the farthest candidate down to the nearest and
   // keeps overwriting, so the nearest requester wins. If nothing is
   // requesting, the pointer comes back unchanged. Callers only use the result
   // when at least one request is set.
   // --------------------------------------------------------------------------
   function automatic logic [IDX_W-1:0] next_winner(
      input logic [SIZE-1:0]  req,
      input logic [IDX_W-1:0] ptr
   );
      logic [IDX_W-1:0] win;
      logic [IDX_W-1:0] cand;
      win = ptr;
      for (int k = SIZE; k >= 1; k--) begin
         cand = IDX_W'((int'(ptr) + k) % SIZE);
         if (req[cand]) begin
            win = cand;
         end
      end
      return win;
   endfunction

   // NOTE: every variable written in an always_comb gets a default value
   // first. Without it, any path that skips the assignment infers a latch.
   always_comb begin
      winner             = next_winner(i_req, o_gnt_idx);
      win_onehot         = '0;
      win_onehot[winner] = 1'b1;
   end

   // The timeout compare is always built. TIMEOUT_EN drops it from the
   // release term when the feature is not compiled in.
   assign timeout_hit  = (o_hold_cnt == HOLD_LIM);

   // A done pulse and a request drop in the same cycle are one release.
   assign release_cond = i_done
                       | ~i_req[o_gnt_idx]
                       | (TIMEOUT_EN & timeout_hit);

   // --------------------------------------------------------------------------
   // Scheduler FSM. The outputs are updated in the same block, so they change
   // on the same edge as the state.
   //    IDLE    -> GRANT    when any request is set
   //    GRANT   -> RELEASE  on done, owner request drop, or timeout
   //    RELEASE -> IDLE     always, after exactly one cycle
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. Every flop then
   // samples values from before the edge, whatever the statement order.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state      <= ST_IDLE;
         o_gnt      <= '0;
         o_gnt_idx  <= IDX_RESET;
         o_valid    <= 1'b0;
         o_hold_cnt <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (|i_req) begin
                  state      <= ST_GRANT;
                  o_gnt      <= win_onehot;
                  o_gnt_idx  <= winner;
                  o_valid    <= 1'b1;
                  o_hold_cnt <= HOLD_W'(1);
               end
            end

            ST_GRANT: begin
               if (release_cond) begin
                  // o_gnt_idx keeps the last owner. It is the priority pointer.
                  state      <= ST_RELEASE;
                  o_gnt      <= '0;
                  o_valid    <= 1'b0;
                  o_hold_cnt <= '0;
               end else if (o_hold_cnt != HOLD_SAT) begin
                  o_hold_cnt <= o_hold_cnt + HOLD_W'(1);
               end
            end

            ST_RELEASE: begin
               // Mandatory bubble. Requests raised meanwhile are seen in IDLE.
               state <= ST_IDLE;
            end

            default: begin
               state      <= ST_IDLE;
               o_gnt      <= '0;
               o_valid    <= 1'b0;
               o_hold_cnt <= '0;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Structural invariants of the registered outputs.
   // --------------------------------------------------------------------------
`ifndef SYNTHESIS
   a_valid_is_or_of_gnt : assert property (
      @(posedge i_clk) disable iff (!i_arst_n)
      o_valid == (|o_gnt)
   );

   a_gnt_onehot0 : assert property (
      @(posedge i_clk) disable iff (!i_arst_n)
      $onehot0(o_gnt)
   );

   a_gnt_matches_idx : assert property (
      @(posedge i_clk) disable iff (!i_arst_n)
      o_valid |-> o_gnt[o_gnt_idx]
   );
`endif

endmodule

// File: tb/tb_svi_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_svi_rr_scheduler
//
// Bench for svi_rr_scheduler. The reference model tracks ownership as plain
// integers:
//    m_owner   current owner lane, or -1 when there is none
//    m_last    last lane granted (the priority pointer)
//    m_held    cycles the current owner has held the grant
//    m_gap     bubble cycles left before the next arbitration
// The model is updated once per rising edge from the inputs sampled at that
// edge. DUT outputs are compared 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_svi_rr_scheduler;

   localparam int SIZE     = 8;
   localparam int HOLD_MAX = 4;
   localparam int IDX_W    = $clog2(SIZE);
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
   localparam int HOLD_TOP = (1 << HOLD_W) - 1;
   localparam int PW       = SIZE + IDX_W + 1 + HOLD_W;

`ifdef SVI_RR_SCHED_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic              i_clk    = 1'b0;
   logic              i_arst_n = 1'b0;
   logic [SIZE-1:0]   i_req    = '0;
   logic              i_done   = 1'b0;
   logic [SIZE-1:0]   o_gnt;
   logic [IDX_W-1:0]  o_gnt_idx;
   logic              o_valid;
   logic [HOLD_W-1:0] o_hold_cnt;

   int n_checks = 0;
   int n_errors = 0;

   int m_owner;
   int m_last;
   int m_held;
   int m_gap;

   svi_rr_scheduler #(
      .SIZE     (SIZE),
      .HOLD_MAX (HOLD_MAX)
   ) dut (
      .i_clk      (i_clk),
      .i_arst_n   (i_arst_n),
      .i_req      (i_req),
      .i_done     (i_done),
      .o_gnt      (o_gnt),
      .o_gnt_idx  (o_gnt_idx),
      .o_valid    (o_valid),
      .o_hold_cnt (o_hold_cnt)
   );

   always #5 i_clk = ~i_clk;

   // ---------------------------------------------------------------- model --
   function automatic bit lane_req(input logic [SIZE-1:0] v, input int lane);
      return ((v >> lane) & SIZE'(1)) != '0;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = SIZE - 1;
      m_held  = 0;
      m_gap   = 0;
   endtask

   task automatic model_edge(input logic [SIZE-1:0] req, input logic done);
      if (m_owner >= 0) begin
         if (done || !lane_req(req, m_owner) || (TO_EN && m_held == HOLD_MAX)) begin
            m_owner = -1;
            m_held  = 0;
            m_gap   = 1;
         end else if (m_held < HOLD_TOP) begin
            m_held++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (req != '0) begin
         for (int k = 1; k <= SIZE; k++) begin
            int c;
            c = (m_last + k) % SIZE;
            if (lane_req(req, c)) begin
               m_owner = c;
               break;
            end
         end
         m_last = m_owner;
         m_held = 1;
      end
   endtask

   function automatic logic [PW-1:0] exp_pack();
      logic [SIZE-1:0] g;
      g = '0;
      if (m_owner >= 0) g = SIZE'(1) << m_owner;
      return {g, IDX_W'(m_last), (m_owner >= 0), HOLD_W'(m_held)};
   endfunction

   function automatic logic [PW-1:0] act_pack();
      return {o_gnt, o_gnt_idx, o_valid, o_hold_cnt};
   endfunction

   // ------------------------------------------------------------- stimulus --
   task automatic tick();
      logic [SIZE-1:0] r;
      logic            d;
      r = i_req;
      d = i_done;
      @(posedge i_clk);
      model_edge(r, d);
      #1;
   endtask

   task automatic do_reset();
      i_arst_n = 1'b0;
      i_req    = '0;
      i_done   = 1'b0;
      model_reset();
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_arst_n = 1'b1;
   endtask

   // ---------------------------------------------------------------- tests --
   task automatic test_reset();
      logic [PW-1:0] rst_exp;
      rst_exp  = {{SIZE{1'b0}}, IDX_W'(SIZE - 1), 1'b0, {HOLD_W{1'b0}}};
      i_arst_n = 1'b0;
      i_req    = '1;
      i_done   = 1'b0;
      model_reset();
      @(posedge i_clk);
      #1;
      n_checks++;
      if (act_pack() !== rst_exp) begin
         n_errors++;
         $display("FAIL reset_values: got %h expected %h", act_pack(), rst_exp);
      end
      @(negedge i_clk);
      i_arst_n = 1'b1;
      tick();
      n_checks++;
      if (act_pack() !== exp_pack()) begin
         n_errors++;
         $display("FAIL reset_first_grant: got %h expected %h", act_pack(), exp_pack());
      end
      n_checks++;
      if (o_gnt !== SIZE'(1)) begin
         n_errors++;
         $display("FAIL reset_lane0_first: got o_gnt=%b expected lane 0", o_gnt);
      end
   endtask

   task automatic test_sweep();
      int  grants;
      int  cyc;
      int  last_rise;
      logic prev;
      grants    = 0;
      cyc       = 0;
      last_rise = -1;
      do_reset();
      i_req = '1;
      while (grants < SIZE + 1 && cyc < 200) begin
         prev   = o_valid;
         i_done = o_valid;
         tick();
         cyc++;
         n_checks++;
         if (act_pack() !== exp_pack()) begin
            n_errors++;
            $display("FAIL sweep_state cyc %0d: got %h expected %h", cyc, act_pack(), exp_pack());
         end
         if (o_valid && !prev) begin
            n_checks++;
            if (o_gnt_idx !== IDX_W'(grants % SIZE)) begin
               n_errors++;
               $display("FAIL sweep_order grant %0d: got lane %0d expected %0d",
                        grants, o_gnt_idx, grants % SIZE);
            end
            if (last_rise >= 0) begin
               n_checks++;
               if (cyc - last_rise != 3) begin
                  n_errors++;
                  $display("FAIL sweep_spacing: got %0d cycles expected 3", cyc - last_rise);
               end
            end
            last_rise = cyc;
            grants++;
         end
      end
      i_done = 1'b0;
      n_checks++;
      if (grants < SIZE + 1) begin
         n_errors++;
         $display("FAIL sweep_budget: got %0d grants expected %0d", grants, SIZE + 1);
      end
   endtask

   task automatic test_pair();
      int   ord[5];
      int   grants;
      int   cyc;
      logic prev;
      ord    = '{4, 7, 4, 7, 4};
      grants = 0;
      cyc    = 0;
      do_reset();
      i_req = 8'h90;
      while (grants < 5 && cyc < 100) begin
         prev   = o_valid;
         i_done = o_valid;
         tick();
         cyc++;
         n_checks++;
         if (act_pack() !== exp_pack()) begin
            n_errors++;
            $display("FAIL pair_state cyc %0d: got %h expected %h", cyc, act_pack(), exp_pack());
         end
         if (o_valid && !prev) begin
            n_checks++;
            if (o_gnt_idx !== IDX_W'(ord[grants])) begin
               n_errors++;
               $display("FAIL pair_order grant %0d: got lane %0d expected %0d",
                        grants, o_gnt_idx, ord[grants]);
            end
            grants++;
         end
      end
      i_done = 1'b0;
      n_checks++;
      if (grants < 5) begin
         n_errors++;
         $display("FAIL pair_budget: got %0d grants expected 5", grants);
      end
   endtask

   task automatic test_timeout();
      int lane0_cycles;
      int exp_lane0;
      lane0_cycles = 0;
      exp_lane0    = TO_EN ? HOLD_MAX : 10;
      do_reset();
      i_req  = 8'h03;
      i_done = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         tick();
         n_checks++;
         if (act_pack() !== exp_pack()) begin
            n_errors++;
            $display("FAIL timeout_state cyc %0d: got %h expected %h", c, act_pack(), exp_pack());
         end
         if (o_gnt === SIZE'(1)) lane0_cycles++;
      end
      n_checks++;
      if (lane0_cycles != exp_lane0) begin
         n_errors++;
         $display("FAIL timeout_lane0_hold: got %0d cycles expected %0d", lane0_cycles, exp_lane0);
      end
   endtask

   task automatic test_req_drop();
      do_reset();
      i_req = 8'h08;
      tick();
      tick();
      n_checks++;
      if (act_pack() !== exp_pack()) begin
         n_errors++;
         $display("FAIL drop_owner: got %h expected %h", act_pack(), exp_pack());
      end
      i_req = 8'h00;
      tick();
      n_checks++;
      if (o_gnt !== '0 || o_valid !== 1'b0 || o_gnt_idx !== IDX_W'(3)) begin
         n_errors++;
         $display("FAIL drop_release: got gnt=%b valid=%b idx=%0d expected 0/0/3",
                  o_gnt, o_valid, o_gnt_idx);
      end
      i_req = 8'h08;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (act_pack() !== exp_pack()) begin
            n_errors++;
            $display("FAIL drop_after %0d: got %h expected %h", c, act_pack(), exp_pack());
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      i_req = 8'h20;
      repeat (3) tick();
      n_checks++;
      if (o_gnt !== 8'h20) begin
         n_errors++;
         $display("FAIL areset_owner: got o_gnt=%b expected lane 5", o_gnt);
      end
      #2;
      i_arst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (o_gnt !== '0 || o_valid !== 1'b0 || o_hold_cnt !== '0 || o_gnt_idx !== IDX_W'(SIZE - 1)) begin
         n_errors++;
         $display("FAIL areset_immediate: got gnt=%b valid=%b hold=%0d idx=%0d expected 0/0/0/%0d",
                  o_gnt, o_valid, o_hold_cnt, o_gnt_idx, SIZE - 1);
      end
      i_req = '1;
      @(negedge i_clk);
      i_arst_n = 1'b1;
      tick();
      n_checks++;
      if (o_gnt !== SIZE'(1) || act_pack() !== exp_pack()) begin
         n_errors++;
         $display("FAIL areset_regrant: got %h expected %h", act_pack(), exp_pack());
      end
   endtask

   task automatic test_single();
      int   cyc;
      int   last_rise;
      int   rises;
      logic prev;
      last_rise = -1;
      rises     = 0;
      do_reset();
      i_req = 8'h40;
      for (cyc = 1; cyc <= 13; cyc++) begin
         prev   = o_valid;
         i_done = o_valid;
         tick();
         n_checks++;
         if (act_pack() !== exp_pack()) begin
            n_errors++;
            $display("FAIL single_state cyc %0d: got %h expected %h", cyc, act_pack(), exp_pack());
         end
         if (o_valid && !prev) begin
            rises++;
            if (last_rise >= 0) begin
               n_checks++;
               if (cyc - last_rise != 3) begin
                  n_errors++;
                  $display("FAIL single_period: got %0d expected 3", cyc - last_rise);
               end
            end
            last_rise = cyc;
         end
      end
      i_done = 1'b0;
      n_checks++;
      if (rises != 5) begin
         n_errors++;
         $display("FAIL single_count: got %0d grants expected 5", rises);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) i_req = SIZE'($urandom);
         i_done = ($urandom_range(0, 4) == 0);
         tick();
         n_checks++;
         if (act_pack() !== exp_pack()) begin
            n_errors++;
            $display("FAIL random_state cyc %0d: got %h expected %h", c, act_pack(), exp_pack());
         end
      end
      i_done = 1'b0;
   endtask

   // ----------------------------------------------------------------- main --
   initial begin
      test_reset();
      test_sweep();
      test_pair();
      test_timeout();
      test_req_drop();
      test_async_reset();
      test_single();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
